// File: rtl/id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_stage
// ID/EX pipeline register with integrated load-use hazard detection.
//
// Captures decoded operands, register numbers and control bits from ID and
// presents them to EX. A load in EX whose destination matches a source of the
// instruction in ID raises a combinational stall and loads a bubble on the next
// edge. A branch flush also loads a bubble, without counting it. A global
// freeze holds every register.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   freeze, flush         pipeline hold / kill of the ID instruction
//   id_*                  decoded fields from the ID stage
//   stall                 combinational hold request to PC and IF/ID
//   ex_*                  registered fields presented to EX / forwarding unit
//   stall_count           saturating count of load-use bubble cycles
// -----------------------------------------------------------------------------
module id_ex_hazard_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              freeze,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [DATA_W-1:0] id_read_data1,
   input  logic [DATA_W-1:0] id_read_data2,
   input  logic [DATA_W-1:0] id_sign_imm,
   input  logic              id_reg_dst,
   input  logic              id_alu_src,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              id_reg_write,
   input  logic [1:0]        id_alu_op,
   output logic              stall,
   output logic              ex_valid,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_write_reg,
   output logic [DATA_W-1:0] ex_read_data1,
   output logic [DATA_W-1:0] ex_read_data2,
   output logic [DATA_W-1:0] ex_sign_imm,
   output logic              ex_alu_src,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              ex_reg_write,
   output logic [1:0]        ex_alu_op,
   output logic [CNT_W-1:0]  stall_count
);

   logic              valid_q, valid_d;
   logic [REG_W-1:0]  rs_q, rs_d;
   logic [REG_W-1:0]  rt_q, rt_d;
   logic [REG_W-1:0]  write_reg_q, write_reg_d;
   logic [DATA_W-1:0] rd1_q, rd1_d;
   logic [DATA_W-1:0] rd2_q, rd2_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic              alu_src_q, alu_src_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic              reg_write_q, reg_write_d;
   logic [1:0]        alu_op_q, alu_op_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              hazard;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign hazard = valid_q & mem_read_q & (rt_q != '0) & id_valid &
                   ((rt_q == id_rs) | (rt_q == id_rt));
   assign stall  = hazard & ~flush & ~freeze;

   always_comb begin
      valid_d      = valid_q;
      rs_d         = rs_q;
      rt_d         = rt_q;
      write_reg_d  = write_reg_q;
      rd1_d        = rd1_q;
      rd2_d        = rd2_q;
      imm_d        = imm_q;
      alu_src_d    = alu_src_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_to_reg_d = mem_to_reg_q;
      reg_write_d  = reg_write_q;
      alu_op_d     = alu_op_q;
      cnt_d        = cnt_q;
      if (!freeze) begin
         if (flush || hazard) begin
            // Bubble: everything cleared so forwarding sees register 0.
            valid_d      = 1'b0;
            rs_d         = '0;
            rt_d         = '0;
            write_reg_d  = '0;
            rd1_d        = '0;
            rd2_d        = '0;
            imm_d        = '0;
            alu_src_d    = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            reg_write_d  = 1'b0;
            alu_op_d     = '0;
            // Only load-use bubbles are counted; flush has priority.
            if (!flush && !(&cnt_q)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            valid_d      = id_valid;
            rs_d         = id_rs;
            rt_d         = id_rt;
            write_reg_d  = id_reg_dst ? id_rd : id_rt;
            rd1_d        = id_read_data1;
            rd2_d        = id_read_data2;
            imm_d        = id_sign_imm;
            alu_src_d    = id_alu_src;
            // Side-effecting controls of an empty slot are suppressed.
            mem_read_d   = id_mem_read & id_valid;
            mem_write_d  = id_mem_write & id_valid;
            mem_to_reg_d = id_mem_to_reg;
            reg_write_d  = id_reg_write & id_valid;
            alu_op_d     = id_alu_op;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q      <= 1'b0;
         rs_q         <= '0;
         rt_q         <= '0;
         write_reg_q  <= '0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         imm_q        <= '0;
         alu_src_q    <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         alu_op_q     <= '0;
         cnt_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         write_reg_q  <= write_reg_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         imm_q        <= imm_d;
         alu_src_q    <= alu_src_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         reg_write_q  <= reg_write_d;
         alu_op_q     <= alu_op_d;
         cnt_q        <= cnt_d;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_rs         = rs_q;
   assign ex_rt         = rt_q;
   assign ex_write_reg  = write_reg_q;
   assign ex_read_data1 = rd1_q;
   assign ex_read_data2 = rd2_q;
   assign ex_sign_imm   = imm_q;
   assign ex_alu_src    = alu_src_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_mem_write  = mem_write_q;
   assign ex_mem_to_reg = mem_to_reg_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_alu_op     = alu_op_q;
   assign stall_count   = cnt_q;

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register (pipeline register 2) with integrated load-use hazard detection.
- Captures decoded operands, register numbers and control bits from ID. Supplies rs/rt to the forwarding unit and rd/reg_write to the EX/MEM register.
- Inserts a one-cycle bubble on a load-use hazard or a branch flush, and drives the stall request to the PC/IF-ID logic.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- DATA_W, 32, width of operand and immediate datapaths.
- REG_W, 5, register-number width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- freeze  input  1  global pipeline freeze; stage holds contents.
- flush  input  1  branch-resolution kill of the instruction in ID.
- id_valid  input  1  ID slot holds a real instruction.
- id_rs, id_rt, id_rd  input  REG_W each  decoded register numbers.
- id_read_data1, id_read_data2  input  DATA_W each  register-file read data.
- id_sign_imm  input  DATA_W  sign-extended immediate.
- id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write  input  1 each  decoded control bits.
- id_alu_op  input  2  ALU op class.
- stall  output  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  output  1  registered valid.
- ex_rs, ex_rt  output  REG_W  registered; feed the forwarding unit.
- ex_write_reg  output  REG_W  registered destination: id_rd if id_reg_dst=1, else id_rt.
- ex_read_data1, ex_read_data2, ex_sign_imm  output  DATA_W  registered data.
- ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  output  1  registered controls.
- ex_alu_op  output  2  registered.
- stall_count  output  CNT_W  saturating count of hazard-bubble cycles.

Behaviour:
- Reset (async, active-high): every ex_* output and stall_count go to 0 immediately. stall therefore reads 0. Reset asserted mid-stall discards the pending hazard.
- hazard (combinational) = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- stall = hazard & ~flush & ~freeze.
- Per-edge priority: reset > freeze > flush > hazard > normal load.
  - freeze=1: all registers hold; stall_count holds; flush/hazard ignored. A flush source must hold flush until freeze drops.
  - flush=1: load a bubble.
  - hazard=1: load a bubble; stall_count += 1, saturating at all-ones (no wrap).
  - Otherwise: capture all id_* fields; ex_valid <= id_valid.
- Bubble definition:
  - ex_valid, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_src = 0.
  - ex_alu_op = 0, ex_write_reg = 0.
  - Data, rs and rt fields also cleared to 0, so the forwarding unit sees register 0 and never forwards.
- Controls of an invalid ID slot (id_valid=0) are captured but masked: ex_reg_write, ex_mem_read and ex_mem_write load as 0.
- Latency: 1 cycle ID->EX. A load-use hazard produces exactly one stall cycle, because the bubble clears ex_mem_read on the next edge.
- Back-to-back loads with the dependent instruction following: each costs one bubble; no accumulation.
- stall_count is not affected by flush bubbles.

Test Plan:
- Reset asserted asynchronously between edges with ex_reg_write=1, stall_count=5 -> all outputs 0 before the next edge; stall=0.
- Normal capture: id_rs=3, id_rt=4, id_rd=5, id_reg_dst=1, id_reg_write=1, data1=0x11, data2=0x22 -> next cycle ex_rs=3, ex_rt=4, ex_write_reg=5, ex_reg_write=1, data passed unchanged.
- Load-use: EX holds lw with ex_rt=8; ID has id_rs=8 -> stall=1 for one cycle; next edge bubble (ex_valid=0, ex_reg_write=0); stall_count 0->1; following cycle stall=0 and the add is captured.
- No false hazard: ex_mem_read=1, ex_rt=0, id_rs=0 -> stall=0. Also ex_mem_read=0, ex_rt=id_rs=8 -> stall=0.
- Flush + hazard in the same cycle -> stall=0; bubble loaded; stall_count unchanged.
- freeze=1 with a pending hazard for 3 cycles -> outputs and stall_count hold, stall=0. freeze drops -> stall=1, one bubble. Also saturation: preload stall_count=0xFFFF, trigger a hazard -> stays 0xFFFF.
